// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Purpose: shared op codes, FSM state encoding and sizing for the HI/LO multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hilo_muldiv_ctrl_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIX   = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Purpose: request/response bundle between the main control unit and the HI/LO sequencer.
// Latency: n/a (wiring only).
// Backpressure: master must hold off issuing while busy is high; starts seen while busy are dropped.
// Ports: start/op/rs_val/rt_val from master; busy/done/div_zero/hi_we/lo_we/hi_wdata/lo_wdata from slave.
interface hilo_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, div_zero, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, div_zero, hi_we, lo_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_iter.sv
// Purpose: iterative datapath: 2*WIDTH accumulator, shift-add multiply / restoring divide, step counter, sign fix.
// Latency: one bit per step; WIDTH steps after load, o_last high during the final step.
// Backpressure: none; advances only when the controller asserts i_step / i_fix.
// Ports: i_load/i_step/i_fix/i_is_div/i_is_signed control, i_a/i_b operands, o_last, o_res_hi/o_res_lo sign-corrected result.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = hilo_muldiv_ctrl_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic             i_is_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_sa;
    logic               r_sb;
    logic [CW-1:0]      r_cnt;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_fixed;

    // The most negative value negates to itself, which read unsigned is the correct magnitude.
    assign w_neg_a = i_is_signed & i_a[WIDTH-1];
    assign w_neg_b = i_is_signed & i_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -i_a : i_a;
    assign w_mag_b = w_neg_b ? -i_b : i_b;

    assign w_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo = r_acc[WIDTH-1:0];

    // Multiply: low half holds the multiplier and shifts out LSB-first; the carry shifts into the top.
    assign w_sum = {1'b0, w_hi} + ({1'b0, r_b} & {(WIDTH+1){w_lo[0]}});

    // Divide: partial remainder stays below the divisor, so the MSB of w_diff is a clean borrow flag.
    assign w_rem_sh = {w_hi, w_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    always_comb begin
        w_fixed = r_acc;
        if (i_is_div) begin
            w_fixed[WIDTH-1:0]       = (r_sa ^ r_sb) ? -w_lo : w_lo;
            w_fixed[2*WIDTH-1:WIDTH] = r_sa ? -w_hi : w_hi;
        end else if (r_sa ^ r_sb) begin
            w_fixed = -r_acc;
        end
    end

    assign o_last   = (r_cnt == '0);
    assign o_res_hi = w_fixed[2*WIDTH-1:WIDTH];
    assign o_res_lo = w_fixed[WIDTH-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            r_b   <= w_mag_b;
            r_sa  <= w_neg_a;
            r_sb  <= w_neg_b;
            r_cnt <= CW'(WIDTH-1);
        end else if (i_step) begin
            r_cnt <= r_cnt - CW'(1);
            if (!i_is_div) begin
                r_acc <= {w_sum, w_lo[WIDTH-1:1]};
            end else if (!w_diff[WIDTH]) begin
                r_acc <= {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
            end else begin
                r_acc <= {w_rem_sh[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
            end
        end else if (i_fix) begin
            r_acc <= w_fixed;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Purpose: HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO, producing one-cycle HI/LO write enables.
// Latency: arithmetic write 34 cycles after acceptance; MTHI/MTLO and divide-by-zero after 1 cycle.
// Backpressure: busy high from acceptance until the cycle after done; start outside IDLE is dropped.
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport of hilo_muldiv_ctrl_if).
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    hilo_muldiv_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_next;
    logic             r_is_div;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic             r_hi_we;
    logic             r_lo_we;
    logic [WIDTH-1:0] r_hi_wdata;
    logic [WIDTH-1:0] r_lo_wdata;

    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_acc_mthi;
    logic             w_acc_mtlo;
    logic             w_acc_dz;
    logic             w_last;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    muldiv_iter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_fix       (w_fix),
        .i_is_div    (r_is_div),
        .i_is_signed (op_is_signed(bus.op)),
        .i_a         (bus.rs_val),
        .i_b         (bus.rt_val),
        .o_last      (w_last),
        .o_res_hi    (w_res_hi),
        .o_res_lo    (w_res_lo)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_fix      = 1'b0;
        w_acc_mthi = 1'b0;
        w_acc_mtlo = 1'b0;
        w_acc_dz   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op_is_arith(bus.op)) begin
                        // A zero divisor never enters CALC; it is reported straight from WRITE.
                        if (op_is_div(bus.op) && (bus.rt_val == '0)) begin
                            w_acc_dz = 1'b1;
                            w_next   = ST_WRITE;
                        end else begin
                            w_load = 1'b1;
                            w_next = ST_CALC;
                        end
                    end else if (bus.op == OP_MTHI) begin
                        w_acc_mthi = 1'b1;
                        w_next     = ST_WRITE;
                    end else if (bus.op == OP_MTLO) begin
                        w_acc_mtlo = 1'b1;
                        w_next     = ST_WRITE;
                    end
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix  = 1'b1;
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered one edge ahead of the state they describe, so they line up with WRITE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_div   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_we    <= 1'b0;
            r_lo_we    <= 1'b0;
            r_hi_wdata <= '0;
            r_lo_wdata <= '0;
        end else begin
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_we    <= 1'b0;
            r_lo_we    <= 1'b0;
            if (w_load) begin
                r_is_div <= op_is_div(bus.op);
            end
            if (w_acc_mthi) begin
                r_hi_we    <= 1'b1;
                r_hi_wdata <= bus.rs_val;
                r_done     <= 1'b1;
            end
            if (w_acc_mtlo) begin
                r_lo_we    <= 1'b1;
                r_lo_wdata <= bus.rs_val;
                r_done     <= 1'b1;
            end
            if (w_acc_dz) begin
                r_div_zero <= 1'b1;
                r_done     <= 1'b1;
            end
            if (w_fix) begin
                r_hi_we    <= 1'b1;
                r_lo_we    <= 1'b1;
                r_hi_wdata <= w_res_hi;
                r_lo_wdata <= w_res_lo;
                r_done     <= 1'b1;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi_we    = r_hi_we;
    assign bus.lo_we    = r_lo_we;
    assign bus.hi_wdata = r_hi_wdata;
    assign bus.lo_wdata = r_lo_wdata;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Purpose: self-checking bench for hilo_muldiv_ctrl: directed test-plan cases plus randomized traffic.
// Latency: model predicts write 34 cycles after arithmetic acceptance, 1 cycle otherwise.
// Backpressure: starts issued while busy are expected to be dropped.
module tb_hilo_muldiv_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result of one request, straight from the instruction semantics.
    function automatic void model_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          output logic [31:0] hi, output logic [31:0] lo,
                                          output logic hwe, output logic lwe, output logic dz,
                                          output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub, uq, ur;
        hi = '0; lo = '0; hwe = 1'b0; lwe = 1'b0; dz = 1'b0; lat = 34;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; hwe = 1'b1; lwe = 1'b1; end
            3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; hwe = 1'b1; lwe = 1'b1; end
            3'd2: begin
                if (b == 32'd0) begin dz = 1'b1; lat = 1; end
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; hwe = 1'b1; lwe = 1'b1; end
            end
            3'd3: begin
                if (b == 32'd0) begin dz = 1'b1; lat = 1; end
                else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; hwe = 1'b1; lwe = 1'b1; end
            end
            3'd4: begin hi = a; hwe = 1'b1; lat = 1; end
            default: begin lo = a; lwe = 1'b1; lat = 1; end
        endcase
    endfunction

    // Model state: busy cycles left for the request in flight, plus the pending result.
    int          m_left = 0;
    logic        m_busy = 0, m_done = 0, m_dz = 0, m_hwe = 0, m_lwe = 0;
    logic [31:0] m_hd = 0, m_ld = 0;
    logic [31:0] p_hi, p_lo;
    logic        p_hwe, p_lwe, p_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0; m_dz = 0; m_hwe = 0; m_lwe = 0; m_hd = 0; m_ld = 0;
        end else begin
            m_done = 0; m_dz = 0; m_hwe = 0; m_lwe = 0;
            if (m_left == 0) begin
                if (bus.start && bus.op <= 3'd5)
                    model_compute(bus.op, bus.rs_val, bus.rt_val, p_hi, p_lo, p_hwe, p_lwe, p_dz, m_left);
            end else begin
                m_left--;
            end
            m_busy = (m_left != 0);
            if (m_left == 1) begin
                m_done = 1'b1; m_dz = p_dz; m_hwe = p_hwe; m_lwe = p_lwe;
                if (p_hwe) m_hd = p_hi;
                if (p_lwe) m_ld = p_lo;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",     {63'd0, bus.busy},     {63'd0, m_busy});
            chk("done",     {63'd0, bus.done},     {63'd0, m_done});
            chk("div_zero", {63'd0, bus.div_zero}, {63'd0, m_dz});
            chk("hi_we",    {63'd0, bus.hi_we},    {63'd0, m_hwe});
            chk("lo_we",    {63'd0, bus.lo_we},    {63'd0, m_lwe});
            chk("hi_wdata", {32'd0, bus.hi_wdata}, {32'd0, m_hd});
            chk("lo_wdata", {32'd0, bus.lo_wdata}, {32'd0, m_ld});
        end
    end

    // Directed request with hand-computed expectations for the write cycle and busy length.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ehwe, input logic elwe, input logic edz, input int elat);
        int nb   = 0;
        int jd   = -1;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
        @(posedge clk); #2;
        bus.start = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) begin
                jd = j;
                chk({nm, ".hi_we"},    {63'd0, bus.hi_we},    {63'd0, ehwe});
                chk({nm, ".lo_we"},    {63'd0, bus.lo_we},    {63'd0, elwe});
                chk({nm, ".div_zero"}, {63'd0, bus.div_zero}, {63'd0, edz});
                if (ehwe) chk({nm, ".hi"}, {32'd0, bus.hi_wdata}, {32'd0, ehi});
                if (elwe) chk({nm, ".lo"}, {32'd0, bus.lo_wdata}, {32'd0, elo});
            end
            if (!bus.busy) break;
        end
        chk({nm, ".busy_cycles"}, 64'(nb), 64'(elat));
        chk({nm, ".done_cycle"},  64'(jd), 64'(elat - 1));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.rs_val = '0; bus.rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy",  {63'd0, bus.busy},  64'd0);
        chk("reset.done",  {63'd0, bus.done},  64'd0);
        chk("reset.we",    {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
        chk("reset.wdata", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1, 1, 0, 34);
        do_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 1, 0, 34);
        do_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1, 0, 34);
        do_op("divu",      3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1, 1, 0, 34);
        do_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1, 1, 0, 34);
        do_op("divu_zero", 3'd3, 32'd5,         32'd0,         32'd0,         32'd0,         0, 0, 1, 1);
        do_op("mthi",      3'd4, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'd0,         1, 0, 0, 1);
        do_op("mtlo",      3'd5, 32'hCAFE_F00D, 32'd0,         32'd0,         32'hCAFE_F00D, 0, 1, 0, 1);
        chk("mtlo.hi_hold", {32'd0, bus.hi_wdata}, 64'h1234_5678);

        // Abort: MULT accepted at T0, stray start at T0+5, reset at T0+10.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy",  {63'd0, bus.busy}, 64'd0);
        chk("abort.we",    {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
        chk("abort.wdata", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        do_op("after_abort", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1, 1, 0, 34);

        // Randomized traffic: starts at any time (dropped while busy), odd ops, occasional resets.
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            bus.start  = ($urandom_range(0, 9) < 3);
            bus.op     = 3'($urandom_range(0, 7));
            bus.rs_val = pick();
            bus.rt_val = pick();
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
